// File: rtl/fault_injector_pkg.sv
// Shared encodings for the voter fault-campaign driver: FSM states, fault kinds,
// counter saturation value and LFSR seed.
package fault_injector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    REPORT = 2'd3
  } fi_state_e;

  typedef enum logic [1:0] {
    KIND_SA0  = 2'b00,
    KIND_SA1  = 2'b01,
    KIND_FLIP = 2'b10,
    KIND_RSVD = 2'b11
  } fi_kind_e;

  localparam logic [15:0] CNT_SAT   = 16'hFFFF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/fault_injector_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick random injection targets.
module fi_lfsr16
  import fault_injector_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic fb;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

endmodule

// File: rtl/fault_injector.sv
// Fault-campaign driver for the redundant ALU voter: injects one masked fault and
// times how long the voter takes to isolate it. Define FI_LFSR_EN for LFSR-chosen targets.
module fault_injector
  import fault_injector_pkg::*;
#(
  parameter int NREP    = 5,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            tgt_rep,
  input  logic [4:0]            tgt_bit,
  input  logic [1:0]            kind,
  input  logic [NREP*WIDTH-1:0] rep_enable,
  output logic [NREP*WIDTH-1:0] and_mask,
  output logic [NREP*WIDTH-1:0] or_mask,
  output logic [NREP*WIDTH-1:0] xor_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  detected,
  output logic                  pre_masked,
  output logic [7:0]            latency,
  output logic                  err,
  output logic [15:0]           inj_count,
  output logic [15:0]           det_count
);

  localparam int NBITS = NREP * WIDTH;
  localparam int IDX_W = $clog2(NBITS);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

  fi_state_e          state, state_nx;
  fi_kind_e           kind_q;
  logic [2:0]         rep_q;
  logic [4:0]         bit_q;
  logic [7:0]         cnt_q;
  logic [7:0]         cnt_inc;
  logic [IDX_W-1:0]   tgt_idx;
  logic               tgt_en;
  logic               tout;
  logic [2:0]         sel_rep;
  logic [4:0]         sel_bit;
  logic               start_bad;
  logic [NBITS-1:0]   and_nx, or_nx, xor_nx;

`ifdef FI_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_sink;

  fi_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Target ports are ignored in this build; only the kind can be rejected.
  assign unused_sink = ^{lfsr[15:8], tgt_rep, tgt_bit};

  always_comb begin
    sel_rep   = 3'(int'(lfsr[2:0]) % NREP);
    sel_bit   = lfsr[7:3];
    start_bad = (kind == KIND_RSVD);
  end
`else
  always_comb begin
    sel_rep   = tgt_rep;
    sel_bit   = tgt_bit;
    start_bad = (int'(tgt_rep) >= NREP) || (kind == KIND_RSVD);
  end
`endif

  assign tgt_idx = IDX_W'(rep_q) * IDX_W'(WIDTH) + IDX_W'(bit_q);
  assign tgt_en  = rep_enable[tgt_idx];
  assign cnt_inc = cnt_q + 8'd1;
  assign tout    = (cnt_inc == 8'(TIMEOUT));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !start_bad) state_nx = ARM;
      ARM:     state_nx = tgt_en ? ACTIVE : REPORT;
      // Detection takes priority when it coincides with the timeout.
      ACTIVE:  if (!tgt_en || tout) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Masks are registered against the next state so they are live exactly in ACTIVE.
  always_comb begin
    and_nx = '1;
    or_nx  = '0;
    xor_nx = '0;
    if (state_nx == ACTIVE) begin
      case (kind_q)
        KIND_SA0:  and_nx[tgt_idx] = 1'b0;
        KIND_SA1:  or_nx[tgt_idx]  = 1'b1;
        KIND_FLIP: xor_nx[tgt_idx] = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      and_mask   <= '1;
      or_mask    <= '0;
      xor_mask   <= '0;
      done       <= 1'b0;
      detected   <= 1'b0;
      pre_masked <= 1'b0;
      latency    <= 8'd0;
      err        <= 1'b0;
      inj_count  <= 16'd0;
      det_count  <= 16'd0;
    end else begin
      state    <= state_nx;
      and_mask <= and_nx;
      or_mask  <= or_nx;
      xor_mask <= xor_nx;
      done     <= 1'b0;
      err      <= 1'b0;

      if (state == IDLE && start) begin
        if (start_bad) begin
          err <= 1'b1;
        end
      end

      if (state_nx == REPORT) begin
        done      <= 1'b1;
        inj_count <= sat_inc(inj_count);
        if (state == ARM) begin
          detected   <= 1'b1;
          pre_masked <= 1'b1;
          latency    <= 8'd0;
          det_count  <= sat_inc(det_count);
        end else begin
          pre_masked <= 1'b0;
          if (!tgt_en) begin
            detected  <= 1'b1;
            latency   <= cnt_inc;
            det_count <= sat_inc(det_count);
          end else begin
            detected <= 1'b0;
            latency  <= 8'(TIMEOUT);
          end
        end
      end
    end
  end

  // Target latch and cycle counter carry no reset; they are only read once loaded.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !start_bad) begin
      rep_q  <= sel_rep;
      bit_q  <= sel_bit;
      kind_q <= fi_kind_e'(kind);
    end
    if (state == ARM) begin
      cnt_q <= 8'd0;
    end else if (state == ACTIVE) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_fault_injector.sv
// Bench for fault_injector: directed scenarios plus randomized injections checked
// against a transaction-level model of mask duration, outcome and counters.
module tb_fault_injector;

  localparam int NR = 5;
  localparam int W  = 32;
  localparam int TO = 16;
  localparam int NB = NR * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    tgt_rep;
  logic [4:0]    tgt_bit;
  logic [1:0]    kind;
  logic [NB-1:0] rep_enable;
  logic [NB-1:0] and_mask, or_mask, xor_mask;
  logic          busy, done, detected, pre_masked, err;
  logic [7:0]    latency;
  logic [15:0]   inj_count, det_count;

  int checks   = 0;
  int failures = 0;
  int m_inj    = 0;
  int m_det    = 0;

  always #5 clk = ~clk;

  fault_injector #(.NREP(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tgt_rep    (tgt_rep),
    .tgt_bit    (tgt_bit),
    .kind       (kind),
    .rep_enable (rep_enable),
    .and_mask   (and_mask),
    .or_mask    (or_mask),
    .xor_mask   (xor_mask),
    .busy       (busy),
    .done       (done),
    .detected   (detected),
    .pre_masked (pre_masked),
    .latency    (latency),
    .err        (err),
    .inj_count  (inj_count),
    .det_count  (det_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected masks: neutral, with one bit altered only while the fault is applied.
  task automatic check_masks(input string tag, input bit on, input int r, input int b, input int k);
    logic [NB-1:0] ea, eo, ex;
    ea = '1; eo = '0; ex = '0;
    if (on) begin
      if (k == 0) ea[r*W+b] = 1'b0;
      if (k == 1) eo[r*W+b] = 1'b1;
      if (k == 2) ex[r*W+b] = 1'b1;
    end
    check_v({tag, "_and"}, and_mask, ea);
    check_v({tag, "_or"},  or_mask,  eo);
    check_v({tag, "_xor"}, xor_mask, ex);
  endtask

  // det_k: ACTIVE cycle in which the voter drops the bit (0 or > TO = never).
  task automatic run_inj(input int r, input int b, input int k, input bit pre,
                         input int det_k, input bit extra_start);
    bit det;
    int L;
    det = pre || (det_k >= 1 && det_k <= TO);
    L   = pre ? 0 : (det ? det_k : TO);
    rep_enable = '1;
    if (pre) rep_enable[r*W+b] = 1'b0;
    tgt_rep = 3'(r); tgt_bit = 5'(b); kind = 2'(k); start = 1'b1;
    step();
    start = 1'b0;
    check_n("arm_busy", 32'(busy), 32'd1);
    check_n("arm_err", 32'(err), 32'd0);
    check_masks("arm", 1'b0, r, b, k);
    for (int c = 1; c <= L + 1; c++) begin
      if (!pre && c - 1 >= 1 && c - 1 == det_k) rep_enable[r*W+b] = 1'b0;
      if (extra_start && c == 2) begin
        start = 1'b1; tgt_rep = 3'((r + 1) % NR); tgt_bit = 5'(b ^ 1); kind = 2'((k + 1) % 3);
      end
      step();
      start = 1'b0;
      check_masks("cyc", (c <= L), r, b, k);
      check_n("done", 32'(done), 32'(c == L + 1));
      if (c == L + 1) begin
        m_inj++;
        if (det) m_det++;
        check_n("detected", 32'(detected), 32'(det));
        check_n("pre_masked", 32'(pre_masked), 32'(pre));
        check_n("latency", 32'(latency), 32'(L));
        check_n("inj_count", 32'(inj_count), 32'(m_inj));
        check_n("det_count", 32'(det_count), 32'(m_det));
      end
    end
    step();
    check_n("idle_busy", 32'(busy), 32'd0);
    check_n("idle_done", 32'(done), 32'd0);
    rep_enable = '1;
  endtask

  task automatic bad_start(input int r, input int k);
    tgt_rep = 3'(r); tgt_bit = 5'd0; kind = 2'(k); start = 1'b1;
    step();
    start = 1'b0;
    check_n("bad_err", 32'(err), 32'd1);
    check_n("bad_busy", 32'(busy), 32'd0);
    step();
    check_n("bad_err_clr", 32'(err), 32'd0);
    check_n("bad_busy2", 32'(busy), 32'd0);
    check_n("bad_inj", 32'(inj_count), 32'(m_inj));
    check_n("bad_det", 32'(det_count), 32'(m_det));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tgt_rep = '0; tgt_bit = '0; kind = '0; rep_enable = '1;
    step(); step();
    check_masks("rst", 1'b0, 0, 0, 0);
    check_n("rst_busy", 32'(busy), 32'd0);
    check_n("rst_done", 32'(done), 32'd0);
    check_n("rst_det", 32'(detected), 32'd0);
    check_n("rst_pre", 32'(pre_masked), 32'd0);
    check_n("rst_err", 32'(err), 32'd0);
    check_n("rst_lat", 32'(latency), 32'd0);
    check_n("rst_inj", 32'(inj_count), 32'd0);
    check_n("rst_detc", 32'(det_count), 32'd0);
    reset = 1'b0;
    step();

    run_inj(2, 7, 2, 1'b0, 3, 1'b0);
    run_inj(0, 0, 1, 1'b0, 0, 1'b0);
    run_inj(4, 31, 0, 1'b1, 0, 1'b0);
    bad_start(5, 0);
    bad_start(1, 3);

    // Reset during the second ACTIVE cycle of a stuck-at-0.
    tgt_rep = 3'd1; tgt_bit = 5'd3; kind = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_masks("act2", 1'b1, 1, 3, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_inj = 0; m_det = 0;
    check_masks("midrst", 1'b0, 0, 0, 0);
    check_n("midrst_busy", 32'(busy), 32'd0);
    check_n("midrst_done", 32'(done), 32'd0);
    check_n("midrst_inj", 32'(inj_count), 32'd0);
    check_n("midrst_det", 32'(det_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_n("post_rst_done", 32'(done), 32'd0);
      check_n("post_rst_busy", 32'(busy), 32'd0);
    end

    run_inj(3, 12, 2, 1'b0, TO, 1'b1);

    for (int t = 0; t < 24; t++) begin
      int r, b, k, dk;
      bit p;
      r  = int'($urandom_range(0, NR - 1));
      b  = int'($urandom_range(0, W - 1));
      k  = int'($urandom_range(0, 2));
      p  = ($urandom_range(0, 4) == 0);
      dk = int'($urandom_range(0, TO + 4));
      run_inj(r, b, k, p, dk, ($urandom_range(0, 3) == 0));
      if (t % 6 == 5) begin
        if ($urandom_range(0, 1) == 0) bad_start(int'($urandom_range(NR, 7)), int'($urandom_range(0, 2)));
        else bad_start(int'($urandom_range(0, NR - 1)), 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
